// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding the UART transmit core: pops one byte per frame window,
// strobes oDE for two cycles and times the window from the line config sampled at pop.
module uart_tx_feeder #(
  parameter int OVER_SAMPLING = 4,
  parameter int DEPTH         = 16,
  parameter int GUARD_CYCLES  = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     iSEVEN_BIT,
  input  logic                     iPARITY_EN,
  input  logic                     iSTOP_BIT,
  input  logic                     iWE,
  input  logic [7:0]               iWDATA,
  input  logic                     iCLR_OVF,
  output logic                     oFULL,
  output logic                     oEMPTY,
  output logic [$clog2(DEPTH):0]   oLEVEL,
  output logic                     oOVERFLOW,
  output logic                     oDE,
  output logic [7:0]               oDATA,
  output logic                     oBUSY
);

  localparam int AW = $clog2(DEPTH);
  // Wide enough for the longest window (12 bits on the line plus guard).
  localparam int TW = $clog2(12*OVER_SAMPLING + GUARD_CYCLES + 1);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q;
  logic          ovf_q;
  logic          full, empty, wr_en, pop;

  state_t        state_q, state_d;
  logic [TW-1:0] t_q, t_d, c_q, c_d;
  logic [7:0]    data_q, data_d;
  logic [3:0]    bits;
  logic [TW-1:0] t_new;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);
  assign wr_en = iWE && !full;
  // Pop decision uses registered emptiness only, so a fresh write never falls through.
  assign pop   = (state_q == IDLE) && !empty;

  assign bits  = 4'd1 + (iSEVEN_BIT ? 4'd7 : 4'd8) + {3'b000, iPARITY_EN} + (iSTOP_BIT ? 4'd2 : 4'd1);
  assign t_new = TW'(bits) * TW'(OVER_SAMPLING) + TW'(GUARD_CYCLES);

  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[wptr_q] <= iWDATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop)   rptr_q <= rptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      // Set has priority over clear.
      if (iWE && full)   ovf_q <= 1'b1;
      else if (iCLR_OVF) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      t_q     <= '0;
      c_q     <= '0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      c_q     <= c_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    c_d     = c_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = SEND;
          t_d     = t_new;
          c_d     = '0;
          data_d  = mem_q[rptr_q];
        end
      end
      SEND: begin
        if (c_q == t_q - TW'(1)) begin
          state_d = IDLE;
          c_d     = '0;
        end else begin
          c_d     = c_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oDE   = (state_q == SEND) && (c_q < TW'(2));
    oBUSY = (state_q != IDLE);
    oDATA = data_q;
  end

  assign oFULL     = full;
  assign oEMPTY    = empty;
  assign oLEVEL    = level_q;
  assign oOVERFLOW = ovf_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench: expected bytes/window lengths are queued at stimulus time and
// checked by a monitor on every oDE rise and oBUSY fall.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;

  logic       CLK = 1'b0, RST_N = 1'b0;
  logic       iSEVEN_BIT = 1'b0, iPARITY_EN = 1'b0, iSTOP_BIT = 1'b0;
  logic       iWE = 1'b0, iCLR_OVF = 1'b0;
  logic [7:0] iWDATA = 8'h00;
  logic       oFULL, oEMPTY, oOVERFLOW, oDE, oBUSY;
  logic [4:0] oLEVEL;
  logic [7:0] oDATA;

  uart_tx_feeder #(.OVER_SAMPLING(4), .DEPTH(DEPTH), .GUARD_CYCLES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .iSEVEN_BIT(iSEVEN_BIT), .iPARITY_EN(iPARITY_EN),
    .iSTOP_BIT(iSTOP_BIT), .iWE(iWE), .iWDATA(iWDATA), .iCLR_OVF(iCLR_OVF),
    .oFULL(oFULL), .oEMPTY(oEMPTY), .oLEVEL(oLEVEL), .oOVERFLOW(oOVERFLOW),
    .oDE(oDE), .oDATA(oDATA), .oBUSY(oBUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [7:0] d; int t; } exp_t;
  exp_t exp_q[$];
  int   rise_q[$];
  int   errors = 0, checks = 0, cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each strobe rise, checks window length on busy fall.
  logic       de_prev = 1'b0, in_frame = 1'b0;
  logic [7:0] held = 8'h00;
  int         bcnt = 0, texp = 0;
  exp_t       e;
  always @(negedge CLK) begin
    if (!RST_N) begin
      de_prev = 1'b0; held = 8'h00; in_frame = 1'b0;
    end else begin
      if (in_frame) begin
        if (oBUSY) bcnt++;
        else begin chk("window_len", bcnt, texp); in_frame = 1'b0; end
      end
      if (oDE && !de_prev) begin
        rise_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_de: got data %0h required no strobe (cycle %0d)", oDATA, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("odata", oDATA, e.d);
          texp = e.t;
        end
        held = oDATA; bcnt = 1; in_frame = 1'b1;
      end else begin
        chk("odata_hold", oDATA, held);
      end
      de_prev = oDE;
    end
  end

  task automatic wr(input logic [7:0] d, input int t, input bit acc);
    iWE = 1'b1; iWDATA = d;
    if (acc) exp_q.push_back('{d, t});
    @(posedge CLK); #1;
    iWE = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((oBUSY || !oEMPTY) && n < maxc) begin @(negedge CLK); n++; end
    if (n >= maxc) begin checks++; errors++; $display("FAIL idle_timeout: got busy required idle"); end
  endtask

  task automatic wait_rises(input int cnt, input int maxc);
    int n = 0;
    while (rise_q.size() < cnt && n < maxc) begin @(negedge CLK); #1; n++; end
    if (n >= maxc) begin checks++; errors++; $display("FAIL rise_timeout: got %0d rises required %0d", rise_q.size(), cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    chk("rst_level", oLEVEL, 0); chk("rst_empty", oEMPTY, 1); chk("rst_full", oFULL, 0);
    chk("rst_ovf", oOVERFLOW, 0); chk("rst_de", oDE, 0); chk("rst_data", oDATA, 0);
    chk("rst_busy", oBUSY, 0);

    // 8N1 single byte: no fall-through, strobe two cycles, T=42.
    @(posedge CLK); #1;
    wr(8'hA5, 42, 1);
    @(negedge CLK); chk("t1_level", oLEVEL, 1); chk("t1_busy_pre", oBUSY, 0);
    @(negedge CLK); chk("t1_busy", oBUSY, 1); chk("t1_de0", oDE, 1); chk("t1_data", oDATA, 8'hA5);
    chk("t1_empty", oEMPTY, 1);
    @(negedge CLK); chk("t1_de1", oDE, 1);
    @(negedge CLK); chk("t1_de2", oDE, 0);
    wait_idle(100);

    // 8E2 back-to-back: T=50, spacing 51.
    iPARITY_EN = 1'b1; iSTOP_BIT = 1'b1;
    rise_q.delete();
    wr(8'h11, 50, 1); @(negedge CLK); chk("t2_lvl_a", oLEVEL, 1);
    wr(8'h22, 50, 1); @(negedge CLK); chk("t2_lvl_b", oLEVEL, 1);
    wr(8'h33, 50, 1); @(negedge CLK); chk("t2_lvl_c", oLEVEL, 2);
    wait_rises(2, 200); chk("t2_lvl_d", oLEVEL, 1);
    wait_rises(3, 200); chk("t2_lvl_e", oLEVEL, 0);
    wait_idle(200);
    chk("t2_space_a", rise_q[1] - rise_q[0], 51);
    chk("t2_space_b", rise_q[2] - rise_q[1], 51);

    // Overflow while a window holds the FSM in SEND.
    iPARITY_EN = 1'b0; iSTOP_BIT = 1'b0;
    wr(8'h40, 42, 1);
    repeat (3) @(negedge CLK);
    for (int i = 0; i < DEPTH; i++) wr(8'h50 + 8'(i), 42, 1);
    @(negedge CLK); chk("t3_full", oFULL, 1); chk("t3_level", oLEVEL, 16); chk("t3_ovf0", oOVERFLOW, 0);
    wr(8'h60, 0, 0);
    @(negedge CLK); chk("t3_ovf1", oOVERFLOW, 1); chk("t3_level_drop", oLEVEL, 16);
    iCLR_OVF = 1'b1; wr(8'h61, 0, 0); iCLR_OVF = 1'b0;
    @(negedge CLK); chk("t3_ovf_setwins", oOVERFLOW, 1);
    iCLR_OVF = 1'b1; @(posedge CLK); #1; iCLR_OVF = 1'b0;
    @(negedge CLK); chk("t3_ovf_clr", oOVERFLOW, 0);
    wait_idle(1000);

    // 7N1 (T=38); stop bits changed mid-window affect only the next window (T=42).
    iSEVEN_BIT = 1'b1;
    rise_q.delete();
    wr(8'h77, 38, 1); wr(8'h78, 42, 1);
    wait_rises(1, 50);
    repeat (10) @(negedge CLK);
    iSTOP_BIT = 1'b1;
    wait_idle(200);
    chk("t4_space", rise_q[1] - rise_q[0], 39);
    iSEVEN_BIT = 1'b0; iSTOP_BIT = 1'b0;

    // Reset at c=10 with 4 bytes queued.
    rise_q.delete();
    wr(8'hA1, 42, 1); wr(8'hA2, 42, 1); wr(8'hA3, 42, 1); wr(8'hA4, 42, 1); wr(8'hA5, 42, 1);
    wait_rises(1, 50);
    repeat (10) @(posedge CLK); #1;
    chk("t5_level_pre", oLEVEL, 4);
    RST_N = 1'b0; #1;
    chk("t5_de", oDE, 0); chk("t5_busy", oBUSY, 0); chk("t5_data", oDATA, 0);
    chk("t5_level", oLEVEL, 0); chk("t5_empty", oEMPTY, 1); chk("t5_full", oFULL, 0);
    exp_q.delete();
    repeat (2) @(posedge CLK); #1;
    RST_N = 1'b1;
    rise_q.delete();
    repeat (60) @(negedge CLK);
    chk("t5_no_de", rise_q.size(), 0); chk("t5_idle", oBUSY, 0);

    // Write lands in the first IDLE cycle after a window: pop on the following cycle.
    wr(8'hC1, 42, 1);
    wait_rises(1, 50);
    wait_idle(100);
    wr(8'hC2, 42, 1);
    @(negedge CLK); chk("t6_busy", oBUSY, 0); chk("t6_level", oLEVEL, 1); chk("t6_de", oDE, 0);
    @(negedge CLK); chk("t6_busy2", oBUSY, 1); chk("t6_de2", oDE, 1); chk("t6_data", oDATA, 8'hC2);
    wait_idle(100);
    chk("t6_space", rise_q[1] - rise_q[0], 44);

    repeat (3) @(negedge CLK);
    chk("exp_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
